// File: rtl/mem_uart_pkg.sv
// Shared definitions for the serial memory-link controller: FSM states,
// header bit positions and the 7-bit/MSB byte formatting helpers.
package mem_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_ACK
    } state_t;

    localparam int HDR_START  = 7;
    localparam int HDR_RD     = 6;
    localparam int HDR_LEN_HI = 1;
    localparam int HDR_LEN_LO = 0;
    localparam int ADDR_BYTES = 5;

    // Low seven bits of byte k of a word; bit 7 stays clear so it never looks like a header.
    function automatic logic [7:0] seg_byte(input logic [31:0] w, input logic [2:0] k);
        logic [31:0] sh;
        sh = w >> {k, 3'b000};
        return {1'b0, sh[6:0]};
    endfunction

    // Collects the bit-7 of each byte; bytes above len contribute 0.
    function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] len);
        return {4'b0000,
                w[31] & (len == 2'd3),
                w[23] & (len >= 2'd2),
                w[15] & (len >= 2'd1),
                w[7]};
    endfunction

endpackage

// File: rtl/mem_uart_arb.sv
// Two-port grant logic for the memory link. Define MEM_ARB_RR_EN for
// round-robin ties; otherwise the data port always wins.
module mem_uart_arb (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant,
    output logic req_any,
    output logic sel_if,
    output logic owner_if
);

    logic favour_if;

`ifdef MEM_ARB_RR_EN
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            favour_if <= 1'b0;
        end else if (grant && req_any) begin
            favour_if <= ~sel_if;
        end
    end
`else
    assign favour_if = 1'b0;
`endif

    assign req_any = if_req | d_req;
    assign sel_if  = if_req & (~d_req | favour_if);

    // Remembers who owns the current transaction so the ack is routed correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_if <= 1'b0;
        end else if (grant && req_any) begin
            owner_if <= sel_if;
        end
    end

endmodule

// File: rtl/mem_uart_ctrl.sv
// Serialises one granted fetch/data request onto the UART memory link and
// assembles read replies. Arbitration variant selected by MEM_ARB_RR_EN.
module mem_uart_ctrl
    import mem_uart_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        if_len,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_len,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              send_flag,
    output logic [7:0]        send_data,
    input  logic              sendable,
    output logic              recv_flag,
    input  logic [7:0]        recv_data,
    input  logic              recvable,
    output logic              busy
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);

    state_t            state, next_state;
    logic [2:0]        cnt;
    logic              we_q;
    logic [1:0]        len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [2:0]        len_p1;
    logic [7:0]        hdr;
    logic              req_any, sel_if, owner_if, rx_fire, grant;

    assign grant = (state == ST_IDLE);

    mem_uart_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant    (grant),
        .req_any  (req_any),
        .sel_if   (sel_if),
        .owner_if (owner_if)
    );

    assign len_p1  = {1'b0, len_q} + 3'd1;
    // RX is drained in every state; only RDATA keeps the bytes.
    assign recv_flag = ~rst;
    assign rx_fire   = recv_flag & recvable;

    always_comb begin
        hdr                        = 8'h00;
        hdr[HDR_START]             = 1'b1;
        hdr[HDR_RD]                = ~we_q;
        hdr[HDR_LEN_HI:HDR_LEN_LO] = len_q;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        send_flag  = 1'b0;
        send_data  = 8'h00;
        unique case (state)
            ST_IDLE: if (req_any) next_state = ST_HDR;
            ST_HDR: begin
                send_flag = 1'b1;
                send_data = hdr;
                if (sendable) next_state = ST_ADDR;
            end
            ST_ADDR: begin
                send_flag = 1'b1;
                send_data = (cnt == ADDR_LAST) ? msb_byte(addr_q, 2'd3) : seg_byte(addr_q, cnt);
                if (sendable && cnt == ADDR_LAST) next_state = we_q ? ST_WDATA : ST_RDATA;
            end
            ST_WDATA: begin
                send_flag = 1'b1;
                send_data = (cnt == len_p1) ? msb_byte(wdata_q, len_q) : seg_byte(wdata_q, cnt);
                if (sendable && cnt == len_p1) next_state = ST_ACK;
            end
            ST_RDATA: if (rx_fire && cnt == {1'b0, len_q}) next_state = ST_ACK;
            ST_ACK:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: the request latches are reset too, so an aborted frame leaves no stale payload behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            we_q    <= 1'b0;
            len_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= next_state;
            if (state != next_state) begin
                cnt <= 3'd0;
            end else if ((send_flag && sendable) || (state == ST_RDATA && rx_fire)) begin
                cnt <= cnt + 3'd1;
            end
            if (state == ST_IDLE && req_any) begin
                we_q    <= sel_if ? 1'b0 : d_we;
                len_q   <= sel_if ? if_len : d_len;
                addr_q  <= sel_if ? if_addr : d_addr;
                wdata_q <= sel_if ? 32'h0 : d_wdata;
                rdata_q <= 32'h0;
            end else if (state == ST_RDATA && rx_fire) begin
                rdata_q[{cnt[1:0], 3'b000} +: 8] <= recv_data;
            end
        end
    end

    assign if_ack   = (state == ST_ACK) &  owner_if;
    assign d_ack    = (state == ST_ACK) & ~owner_if;
    assign if_rdata = if_ack ? rdata_q : 32'h0;
    assign d_rdata  = d_ack  ? rdata_q : 32'h0;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_uart_ctrl.sv
// Directed bench for mem_uart_ctrl: table of link transactions plus
// hand-written stall, abort, stray-RX and arbitration sequences.
module tb_mem_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [1:0]  if_len = 2'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [1:0]  d_len = 2'd0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        send_flag;
    logic [7:0]  send_data;
    logic        sendable = 1'b0;
    logic        recv_flag;
    logic [7:0]  recv_data = 8'h00;
    logic        recvable = 1'b0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_uart_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_len    (if_len),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_len     (d_len),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .send_flag (send_flag),
        .send_data (send_data),
        .sendable  (sendable),
        .recv_flag (recv_flag),
        .recv_data (recv_data),
        .recvable  (recvable),
        .busy      (busy)
    );

    // One link transaction: tx bytes listed first-byte-leftmost in txp, rx byte k in rxw[8k+7:8k].
    typedef struct {
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] rxw;
        int          n_tx;
        logic [95:0] txp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input int vi, input int stall_at, input int stall_len);
        vec_t       v;
        logic [7:0] got [12];
        int         ntx, nrx, cyc, stalled, exp_rx;
        bit         done;
        v = vecs[vi];
        ntx = 0; nrx = 0; cyc = 0; stalled = 0; done = 0;
        exp_rx = v.we ? 0 : int'(v.len) + 1;
        @(negedge clk);
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr; if_len = v.len;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_len = v.len; d_wdata = v.wdata;
        end
        while (!done && cyc < 200) begin
            cyc++;
            sendable = 1'b1;
            if (ntx == stall_at && stalled < stall_len && send_flag) begin
                sendable = 1'b0;
                stalled++;
            end
            recvable  = !v.we && ntx >= 6 && nrx < exp_rx;
            recv_data = 8'(v.rxw >> (8 * nrx));
            #1;
            if (if_ack || d_ack) begin
                done = 1;
                check($sformatf("v%0d_if_ack", vi), {31'b0, if_ack}, {31'b0, v.is_if});
                check($sformatf("v%0d_d_ack", vi), {31'b0, d_ack}, {31'b0, ~v.is_if});
                if (!v.we) check($sformatf("v%0d_rdata", vi), v.is_if ? if_rdata : d_rdata, v.rdata);
                check($sformatf("v%0d_tx_count", vi), ntx, v.n_tx);
                check($sformatf("v%0d_rx_count", vi), nrx, exp_rx);
                check($sformatf("v%0d_latency", vi), cyc, v.n_tx + exp_rx + 2 + stall_len);
                for (int i = 0; i < v.n_tx; i++)
                    check($sformatf("v%0d_tx%0d", vi, i), {24'b0, got[i]}, {24'b0, v.txp[95 - 8 * i -: 8]});
                if_req = 1'b0;
                d_req  = 1'b0;
            end else begin
                if (send_flag && sendable) begin
                    if (ntx < 12) got[ntx] = send_data;
                    ntx++;
                end
                if (recv_flag && recvable) nrx++;
            end
            @(negedge clk);
        end
        if (!done) begin
            check($sformatf("v%0d_ack_timeout", vi), 32'd0, 32'd1);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        recvable = 1'b0;
        #1;
        check($sformatf("v%0d_ack_one_cycle", vi), {30'b0, if_ack, d_ack}, 32'd0);
        check($sformatf("v%0d_idle_after", vi), {31'b0, busy}, 32'd0);
    endtask

    task automatic abort_mid_addr();
        int  ntx, cyc;
        bit  bad;
        ntx = 0; cyc = 0; bad = 0;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h12345678; d_len = 2'd3; d_wdata = 32'hCAFEF00D;
        sendable = 1'b1; recvable = 1'b0;
        while (ntx < 4 && cyc < 50) begin
            cyc++;
            #1;
            if (send_flag && sendable) ntx++;
            @(negedge clk);
        end
        check("abort_reached_addr3", ntx, 4);
        rst   = 1'b1;
        d_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort_flags", {27'b0, send_flag, recv_flag, busy, if_ack, d_ack}, 32'd0);
        check("abort_send_data", {24'b0, send_data}, 32'd0);
        check("abort_rdata", if_rdata | d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (send_flag || if_ack || d_ack || busy) bad = 1;
            @(negedge clk);
        end
        check("abort_quiet_after", {31'b0, bad}, 32'd0);
    endtask

    task automatic arb_both();
        int         nack, cyc;
        logic [3:0] order, exp_order;
        nack = 0; cyc = 0; order = 4'b0;
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; if_len = 2'd0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_len = 2'd0; d_wdata = 32'h5A;
        sendable = 1'b1; recvable = 1'b1; recv_data = 8'h77;
        while (nack < 4 && cyc < 200) begin
            cyc++;
            #1;
            if (if_ack && d_ack) check("arb_double_ack", 32'd1, 32'd0);
            if (if_ack || d_ack) begin
                order[nack] = if_ack;
                nack++;
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0; recvable = 1'b0;
        check("arb_ack_count", nack, 4);
        check("arb_order", {28'b0, order}, {28'b0, exp_order});
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 32'h00000104, 2'd0, 32'h00000041, 32'h0, 8,
                    96'h800401000000_410000000000, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h80001234, 2'd3, 32'h0, 32'hDEADBEEF, 6,
                    96'hC33412000008_000000000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h12345678, 2'd3, 32'hCAFEF00D, 32'h0, 11,
                    96'h837856341200_0D707E4A0E00, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 32'h0, 9,
                    96'h817F7F7F7F0F_7F7F03000000, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h00000080, 2'd0, 32'h0, 32'h000000A5, 6,
                    96'hC00000000001_000000000000, 32'h000000A5};
        vecs[5] = '{1'b1, 1'b0, 32'h00000010, 2'd1, 32'h0, 32'h00002211, 6,
                    96'hC11000000000_000000000000, 32'h00002211};

        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {27'b0, send_flag, recv_flag, busy, if_ack, d_ack}, 32'd0);
        check("reset_data", {24'b0, send_data} | if_rdata | d_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_recv_flag", {31'b0, recv_flag}, 32'd1);

        for (int i = 0; i < 5; i++) run_txn(i, -1, 0);

        run_txn(2, 3, 20);

        abort_mid_addr();
        run_txn(1, -1, 0);

        @(negedge clk);
        recvable  = 1'b1;
        recv_data = 8'h55;
        #1;
        check("stray_rx_consumed", {31'b0, recv_flag & recvable}, 32'd1);
        check("stray_rx_idle", {31'b0, busy}, 32'd0);
        @(negedge clk);
        recvable = 1'b0;
        #1;
        check("stray_rx_no_ack", {30'b0, if_ack, d_ack}, 32'd0);
        run_txn(5, -1, 0);

        arb_both();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
